// File: rtl/dwb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dwb_pkg
// Brief    : Shared types and default sizes for the data-cache write buffer.
// Revision : 1.0
// ============================================================================
package dwb_pkg;

    localparam int C_DEPTH_DEFAULT  = 4;
    localparam int C_ADDR_W_DEFAULT = 6;
    localparam int C_DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_READ      = 2'd1,
        S_DRAIN     = 2'd2,
        S_READ_DONE = 2'd3
    } dwb_state_t;

    typedef struct packed {
        logic [C_ADDR_W_DEFAULT-1:0] addr;
        logic [C_DATA_W_DEFAULT-1:0] data;
    } dwb_entry_t;

endpackage
`default_nettype wire

// File: rtl/dcache_write_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Brief    : Circular write-entry store with age-ordered address lookup that
//            reports a hit and the youngest matching entry's data.
// Revision : 1.0
// ============================================================================
module wb_fifo
    import dwb_pkg::*;
#(
    parameter int DEPTH  = C_DEPTH_DEFAULT,
    parameter int ADDR_W = C_ADDR_W_DEFAULT,
    parameter int DATA_W = C_DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W:0]    r_count;
    logic [PTR_W-1:0]  w_idx;

    // Storage carries no reset; validity is derived from head/count only.
    always_ff @(posedge clk) begin
        if (push) begin
            r_addr[r_tail] <= push_addr;
            r_data[r_tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_tail <= r_tail + 1'b1;
            if (pop)  r_head <= r_head + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_addr = r_addr[r_head];
    assign head_data = r_data[r_head];
    assign full      = (r_count == (PTR_W+1)'(DEPTH));
    assign empty     = (r_count == '0);

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        w_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if (((PTR_W+1)'(k) < r_count) && (r_addr[w_idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = r_data[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dcache_write_buffer
// Brief    : Posted-write buffer between data cache and memory; reads have
//            priority but never overtake an older queued write to the same
//            block. Build option DWB_FORWARD_EN forwards hitting reads.
// Revision : 1.0
// ============================================================================
module dcache_write_buffer
    import dwb_pkg::*;
#(
    parameter int DEPTH  = C_DEPTH_DEFAULT,
    parameter int ADDR_W = C_ADDR_W_DEFAULT,
    parameter int DATA_W = C_DATA_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              c_read,
    input  logic              c_write,
    input  logic [ADDR_W-1:0] c_address,
    input  logic [DATA_W-1:0] c_writedata,
    output logic [DATA_W-1:0] c_readdata,
    output logic              c_busywait,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_busywait
);

    dwb_state_t        r_state;
    dwb_state_t        w_next_state;
    logic              r_started;
    logic [DATA_W-1:0] r_rdata;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_data;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_done;
    logic              w_read_issuable;

    assign w_done          = r_started && !m_busywait &&
                             ((r_state == S_READ) || (r_state == S_DRAIN));
    assign w_read_issuable = c_read && !c_write && !w_hit;
    assign w_push          = c_write && !w_full && !RESET;
    assign w_pop           = (r_state == S_DRAIN) && w_done;

    wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (CLK),
        .rst         (RESET),
        .push        (w_push),
        .push_addr   (c_address),
        .push_data   (c_writedata),
        .pop         (w_pop),
        .head_addr   (w_head_addr),
        .head_data   (w_head_data),
        .full        (w_full),
        .empty       (w_empty),
        .lookup_addr (c_address),
        .hit         (w_hit),
        .hit_data    (w_hit_data)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_started <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_done)
                r_started <= 1'b0;
            else if (((r_state == S_READ) || (r_state == S_DRAIN)) && m_busywait)
                r_started <= 1'b1;
            if ((r_state == S_READ) && w_done)
                r_rdata <= m_readdata;
        end
    end

    always_comb begin
        w_next_state = r_state;
        m_read       = 1'b0;
        m_write      = 1'b0;
        m_address    = '0;
        m_writedata  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_read_issuable)
                    w_next_state = S_READ;
                else if (!w_empty)
                    w_next_state = S_DRAIN;
            end
            S_READ: begin
                m_read    = 1'b1;
                m_address = c_address;
                if (w_done) w_next_state = S_READ_DONE;
            end
            S_DRAIN: begin
                m_write     = 1'b1;
                m_address   = w_head_addr;
                m_writedata = w_head_data;
                if (w_done) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        if (RESET) begin
            m_read      = 1'b0;
            m_write     = 1'b0;
            m_address   = '0;
            m_writedata = '0;
        end
    end

`ifdef DWB_FORWARD_EN
    always_comb begin
        c_busywait = 1'b0;
        c_readdata = r_rdata;
        if (RESET) begin
            c_readdata = '0;
        end else if (c_write) begin
            c_busywait = w_full;
        end else if (c_read) begin
            if (w_hit)
                c_readdata = w_hit_data;
            else
                c_busywait = (r_state != S_READ_DONE);
        end
    end
`else
    logic w_unused_hit_data;
    assign w_unused_hit_data = ^w_hit_data;

    // A hitting read simply stalls until the matching entries have drained.
    always_comb begin
        c_busywait = 1'b0;
        c_readdata = r_rdata;
        if (RESET) begin
            c_readdata = '0;
        end else if (c_write) begin
            c_busywait = w_full;
        end else if (c_read) begin
            c_busywait = (r_state != S_READ_DONE);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_write_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dcache_write_buffer
// Brief    : Scoreboard bench with a latency-modelled memory for the buffer.
// Revision : 1.0
// ============================================================================
module tb_dcache_write_buffer;
    import dwb_pkg::*;

    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 5;
    localparam int TIMEOUT = 500;

    logic              CLK         = 1'b0;
    logic              RESET       = 1'b1;
    logic              c_read      = 1'b0;
    logic              c_write     = 1'b0;
    logic [ADDR_W-1:0] c_address   = '0;
    logic [DATA_W-1:0] c_writedata = '0;
    logic [DATA_W-1:0] c_readdata;
    logic              c_busywait;
    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_address;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata  = '0;
    logic              m_busywait  = 1'b0;

    always #5 CLK = ~CLK;

    dcache_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .c_read      (c_read),
        .c_write     (c_write),
        .c_address   (c_address),
        .c_writedata (c_writedata),
        .c_readdata  (c_readdata),
        .c_busywait  (c_busywait),
        .m_read      (m_read),
        .m_write     (m_write),
        .m_address   (m_address),
        .m_writedata (m_writedata),
        .m_readdata  (m_readdata),
        .m_busywait  (m_busywait)
    );

    int tests = 0;
    int fails = 0;

    logic [ADDR_W-1:0] exp_wr_addr_q [$];
    logic [DATA_W-1:0] exp_wr_data_q [$];
    logic [DATA_W-1:0] exp_rd_q      [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: busy from the cycle after a request for MEM_LAT cycles,
    // then one quiet cycle so the finished request is not re-accepted.
    logic [DATA_W-1:0] mem [64];
    int mstate      = 0;
    int mcnt        = 0;
    int wr_done     = 0;
    int rd_start_wr = -1;

    initial for (int i = 0; i < 64; i++) mem[i] = 32'hCAFE_0000 | i;

    always @(posedge CLK) begin
        if (RESET) begin
            m_busywait <= 1'b0;
            mstate     <= 0;
        end else begin
            case (mstate)
                0: if (m_read || m_write) begin
                    m_busywait <= 1'b1;
                    mcnt       <= MEM_LAT;
                    mstate     <= 1;
                    if (m_read) rd_start_wr <= wr_done;
                end
                1: if (mcnt == 1) begin
                    m_busywait <= 1'b0;
                    mstate     <= 2;
                    if (m_write) begin
                        mem[m_address] = m_writedata;
                        wr_done <= wr_done + 1;
                        if (exp_wr_addr_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL mem_write_unexpected: addr 0x%0h data 0x%0h, none queued",
                                     m_address, m_writedata);
                        end else begin
                            check("mem_write_addr", 64'(m_address), 64'(exp_wr_addr_q.pop_front()));
                            check("mem_write_data", 64'(m_writedata), 64'(exp_wr_data_q.pop_front()));
                        end
                    end else begin
                        m_readdata <= mem[m_address];
                    end
                end else begin
                    mcnt <= mcnt - 1;
                end
                default: mstate <= 0;
            endcase
        end
    end

    // Read-response monitor: a read completes on any cycle the cache sees no stall.
    always @(negedge CLK) begin
        if (!RESET && c_read && !c_write && !c_busywait) begin
            if (exp_rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL read_unexpected: data 0x%0h, none queued", c_readdata);
            end else begin
                check("cache_readdata", 64'(c_readdata), 64'(exp_rd_q.pop_front()));
            end
        end
    end

    task automatic cache_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output int stall);
        exp_wr_addr_q.push_back(a);
        exp_wr_data_q.push_back(d);
        c_write = 1'b1; c_address = a; c_writedata = d; stall = 0;
        @(negedge CLK);
        while (c_busywait && stall < TIMEOUT) begin stall++; @(negedge CLK); end
        if (stall >= TIMEOUT) begin
            tests++; fails++;
            $display("FAIL write_timeout: addr 0x%0h still stalled after %0d cycles", a, stall);
        end
        @(posedge CLK); #1;
        c_write = 1'b0;
    endtask

    task automatic cache_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output int stall);
        exp_rd_q.push_back(d);
        c_read = 1'b1; c_address = a; stall = 0;
        @(negedge CLK);
        while (c_busywait && stall < TIMEOUT) begin stall++; @(negedge CLK); end
        if (stall >= TIMEOUT) begin
            tests++; fails++;
            $display("FAIL read_timeout: addr 0x%0h still stalled after %0d cycles", a, stall);
        end
        @(posedge CLK); #1;
        c_read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_drained(input string name);
        int cyc = 0;
        @(negedge CLK);
        while (!(dut.u_fifo.r_count == 0 && dut.r_state == S_IDLE && mstate == 0) && cyc < 2000) begin
            cyc++; @(negedge CLK);
        end
        check(name, 64'(dut.u_fifo.r_count), 64'd0);
        @(posedge CLK); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int st;
        int st_sum;
        int base;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_m_read",     64'(m_read), 64'd0);
        check("rst_m_write",    64'(m_write), 64'd0);
        check("rst_m_address",  64'(m_address), 64'd0);
        check("rst_c_readdata", 64'(c_readdata), 64'd0);
        check("rst_c_busywait", 64'(c_busywait), 64'd0);
        RESET = 1'b0;
        idle(1);

        // Single write into an empty buffer
        base = wr_done;
        cache_write(6'h0A, 32'h1122_3344, st);
        check("t1_zero_stall", 64'(st), 64'd0);
        wait_drained("t1_count_zero");
        check("t1_one_mem_write", 64'(wr_done - base), 64'd1);

        // Five back-to-back writes: the fifth waits for the first drain
        base   = wr_done;
        st_sum = 0;
        for (int i = 0; i < 4; i++) begin
            cache_write(6'(6'h10 + i), 32'hA000_0000 + i, st);
            st_sum += st;
        end
        check("t2_first4_no_stall", 64'(st_sum), 64'd0);
        cache_write(6'h14, 32'hA000_0004, st);
        check("t2_fifth_stalled", 64'(st > 0), 64'd1);
        check("t2_fifth_after_one_drain", 64'(wr_done - base), 64'd1);
        wait_drained("t2_count_zero");

        // Read miss overtakes the remaining unrelated drain
        base = wr_done;
        cache_write(6'h01, 32'h0101_0101, st);
        cache_write(6'h02, 32'h0202_0202, st);
        cache_read(6'h05, 32'hCAFE_0005, st);
        check("t3_read_before_second_drain", 64'(rd_start_wr - base), 64'd1);
        check("t3_read_latency", 64'(st > MEM_LAT), 64'd1);
        wait_drained("t3_count_zero");

        // Duplicate-address writes then a read of that address
        base = wr_done;
        cache_write(6'h07, 32'h0000_AAAA, st);
        cache_write(6'h07, 32'h0000_BBBB, st);
        cache_read(6'h07, 32'h0000_BBBB, st);
`ifdef DWB_FORWARD_EN
        check("t4_forward_zero_stall", 64'(st), 64'd0);
        check("t4_forward_no_drain_yet", 64'(wr_done - base), 64'd0);
`else
        check("t4_read_after_both_drains", 64'(rd_start_wr - base), 64'd2);
        check("t4_stall_covers_drains", 64'(st > 2 * MEM_LAT), 64'd1);
`endif
        wait_drained("t4_count_zero");
        cache_read(6'h07, 32'h0000_BBBB, st);
        check("t4_memory_read_stalls", 64'(st > 0), 64'd1);

        // Reset in the middle of a drain
        base = wr_done;
        cache_write(6'h20, 32'h2020_2020, st);
        cache_write(6'h21, 32'h2121_2121, st);
        cache_write(6'h22, 32'h2222_2222, st);
        idle(2);
        check("t5_drain_active", 64'(m_write), 64'd1);
        RESET = 1'b1; c_write = 1'b1; c_address = 6'h23; c_writedata = 32'h2323_2323;
        @(negedge CLK);
        check("t5_busywait_low_in_reset", 64'(c_busywait), 64'd0);
        @(posedge CLK); #1;
        RESET = 1'b0; c_write = 1'b0;
        exp_wr_addr_q.delete();
        exp_wr_data_q.delete();
        check("t5_m_write_zero",    64'(m_write), 64'd0);
        check("t5_m_address_zero",  64'(m_address), 64'd0);
        check("t5_m_wdata_zero",    64'(m_writedata), 64'd0);
        check("t5_c_readdata_zero", 64'(c_readdata), 64'd0);
        check("t5_count_zero",      64'(dut.u_fifo.r_count), 64'd0);
        check("t5_no_write_landed", 64'(wr_done - base), 64'd0);
        cache_write(6'h30, 32'h3030_3030, st);
        check("t5_post_write_no_stall", 64'(st), 64'd0);
        wait_drained("t5_post_count_zero");
        cache_read(6'h30, 32'h3030_3030, st);

        // Pointer wrap with drains interleaved
        base = wr_done;
        for (int i = 0; i < 10; i++) begin
            cache_write(6'(6'h2A + i), 32'h6000_0000 + 32'(i) * 32'h111, st);
            idle((i % 3) * 3);
        end
        wait_drained("t6_count_zero");
        check("t6_all_writes_landed", 64'(wr_done - base), 64'd10);

        check("sb_writes_consumed", 64'(exp_wr_addr_q.size()), 64'd0);
        check("sb_reads_consumed",  64'(exp_rd_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_write_buffer.md
Name: dcache_write_buffer

Overview:
- Posted-write buffer between the data cache and data memory.
- Absorbs block write-backs so the cache does not stall for the full memory write latency; entries drain to memory in the background.
- Read misses get priority on the memory port. A read is never issued to memory while an older write to the same block is still queued, which preserves read-after-write ordering.

Parameters:
- DEPTH, 4, number of buffered write entries (power of 2, ≥2)
- ADDR_W, 6, block address width
- DATA_W, 32, block data width

Ports:
- CLK  in  1  clock, all state updates on posedge
- RESET  in  1  synchronous, active-high reset
- c_read  in  1  cache read-miss request, held until c_busywait low
- c_write  in  1  cache write-back request, held until c_busywait low
- c_address  in  ADDR_W  cache block address
- c_writedata  in  DATA_W  write-back block
- c_readdata  out  DATA_W  fetched block, valid in the cycle c_busywait falls for a read
- c_busywait  out  1  stall to cache
- m_read  out  1  memory read request
- m_write  out  1  memory write request
- m_address  out  ADDR_W  memory block address
- m_writedata  out  DATA_W  memory write data
- m_readdata  in  DATA_W  memory read data
- m_busywait  in  1  memory busy; raised the cycle after a request, dropped when done

Behaviour:
- Reset (sync, RESET=1 at posedge):
  - count, head and tail cleared; FSM to IDLE.
  - m_read, m_write, m_address, m_writedata and c_readdata all 0.
  - c_busywait forced 0 while RESET=1.
  - Any in-flight memory transfer is abandoned; memory shares RESET. Buffered entries are lost.
- Cache write:
  - c_write=1 and count<DEPTH: entry {c_address, c_writedata} enqueued at tail at the posedge; c_busywait=0 in that cycle (combinational, zero-stall accept).
  - count==DEPTH: c_busywait=1 until an entry drains. A same-cycle dequeue does not free a slot for that cycle's write.
  - No coalescing: duplicate addresses occupy separate entries, stored in age order.
- c_read and c_write both high is a protocol violation; the write wins and the read is ignored.
- Cache read, address matching no valid entry:
  - c_busywait=1; request is handed to the FSM.
  - Memory data is captured at completion; the next cycle (READ_DONE) has c_readdata=captured and c_busywait=0.
  - Minimum latency: memory latency + 1 cycle.
- Cache read, address matching ≥1 valid entry: see Optional Feature.
- FSM states: IDLE, READ, DRAIN, READ_DONE.
  - IDLE→READ: pending read is issuable. Reads have priority over drain.
  - IDLE→DRAIN: else if count>0.
  - READ/DRAIN:
    - Drive m_read or m_write, plus address and data (head entry for DRAIN).
    - A `started` flag sets the first cycle m_busywait=1.
    - Completion is the first posedge with started=1 and m_busywait=0. At completion the request drops and the FSM returns to IDLE; for READ it goes to READ_DONE.
  - DRAIN completion pops head: head+1 mod DEPTH, count-1.
  - READ_DONE→IDLE after 1 cycle.
- Pointer wrap: head and tail wrap mod DEPTH. Full is count==DEPTH; empty is count==0.
- Enqueue concurrent with drain completion: both apply the same cycle; count is unchanged.

Optional Feature:
- Macro: DWB_FORWARD_EN.
- Defined: a read hitting the buffer returns the youngest matching entry's data combinationally: c_busywait=0 the same cycle, zero cycles, no memory access.
- Undefined: a hitting read keeps c_busywait=1 until all matching entries have drained, then it is issued to memory as a normal read. The read still outranks unrelated drains only once it is issuable.

Decomposition:
- Package dwb_pkg: FSM state enum (IDLE, READ, DRAIN, READ_DONE), default DEPTH/ADDR_W/DATA_W constants, entry struct {addr, data}.
- Sub-module wb_fifo: circular buffer with head/tail/count and a per-entry address compare. Outputs are hit and youngest-hit data.
- The top level holds the FSM and handshakes.

Test Plan:
- Write 0x0A/data 0x11223344 into an empty buffer → c_busywait=0 same cycle. A memory write to 0x0A with 0x11223344 follows; count returns to 0.
- 5 back-to-back writes with DEPTH=4 and memory latency 5 → 5th write stalls until the first drain completes; memory sees the writes in issue order.
- Read 0x05 with buffer holding 0x01,0x02 → m_read issued before the remaining drains. c_readdata equals memory data in READ_DONE, with c_busywait falling that cycle.
- Write 0x07=0xAAAA then 0x07=0xBBBB, then read 0x07:
  - with DWB_FORWARD_EN → 0xBBBB with zero stall;
  - without it → stall until both writes drain, then the memory read returns 0xBBBB.
- Fill 3 entries, assert RESET mid-drain for 1 cycle → all outputs 0 and count 0. A subsequent write/read works normally.
- Wrap: 10 sequential writes with drains interleaved → every address/data pair reaches memory in order across the pointer wrap.
